garbage_queue: RTL and testbench
================================

# garbage_queue

Downstream of the line-clear/attack accounting stage. Watches the cumulative `lines_sent` counter and turns each increase into an outgoing attack. With cancellation compiled in, incoming garbage already queued against this player is cancelled first. Queues attacks received from the opponent as FIFO entries of (row count, hole column), and streams pending rows one per handshake into the playfield after a lock that cleared no lines. Also exports the total pending row count for the garbage loading bar.

## Interface
Parameters:
- `DEPTH`, 8: max queued attack entries (power of two)
- `PLAYFIELD_COLS`, 10: legal hole columns are 0..PLAYFIELD_COLS-1
- `MAX_INSERT`, 8: max rows inserted per qualifying lock

Ports:
- `clk`  in  1  clock
- `rst_l`  in  1  reset, asynchronous, active-low
- `game_start`  in  1  synchronous flush pulse
- `lines_sent`  in  10  cumulative lines-sent counter from upstream
- `lock_done`  in  1  piece-lock pulse
- `lock_cleared`  in  1  any line cleared at this lock; sampled with `lock_done`
- `recv_valid`  in  1  incoming attack valid
- `recv_count`  in  4  incoming rows, 0..15
- `recv_hole`  in  4  incoming hole column
- `recv_ready`  out  1  = !full
- `send_valid`  out  1  outgoing attack valid
- `send_count`  out  10  outgoing rows
- `send_ready`  in  1  network accepts attack
- `insert_valid`  out  1  garbage row offered to playfield
- `insert_hole`  out  4  hole column of offered row
- `insert_ready`  in  1  playfield accepts row
- `garbage_pending`  out  8  sum of queued counts

## Operation
- **Storage:** circular FIFO of {count[3:0], hole[3:0]}, plus head/tail pointers and an occupancy counter.
- **Receive:** a handshake with `recv_count==0` is accepted and discarded. `recv_hole >= PLAYFIELD_COLS` is clamped to PLAYFIELD_COLS-1. Receive is legal in every state.
- **Delta capture:** `delta = lines_sent - lines_sent_q`, computed modulo 2^10. Capture happens only in IDLE, and `lines_sent_q <= lines_sent` on capture.
- **`insert_req` flag:** set by `lock_done && !lock_cleared`. Cleared on entry to INSERT or on `game_start`.
- **FSM states:** IDLE, CANCEL, SEND, INSERT.
  - IDLE priority: `delta!=0` → CANCEL with `rem=delta`; else `insert_req` → INSERT with `budget=MAX_INSERT`; else stay.
  - CANCEL, one step per cycle:
    - If queue empty or `rem==0`: go to SEND if `rem>0`, else IDLE.
    - Else if `rem >= head.count`: `rem -= head.count`, pop head.
    - Else: `head.count -= rem`, `rem=0`.
  - SEND: `send_valid=1`, `send_count=rem`, held stable until `send_ready`; then IDLE.
  - INSERT:
    - `insert_valid = !empty && budget>0`; `insert_hole = head.hole`.
    - On handshake: `head.count -= 1`, pop the entry when it reaches 0, `budget -= 1`.
    - Exit to IDLE when `budget==0` or the queue is empty.
- **`garbage_pending`:** registered. Updated in the same edge as each push, pop or decrement; net change on an edge = +push_count − removed rows. Maximum 15·DEPTH, which fits in 8 bits for DEPTH ≤ 16.
- **`game_start`:** overrides everything. Flushes the FIFO, sets `garbage_pending=0`, `lines_sent_q=0`, `rem=0`, `insert_req=0`, state IDLE. An in-flight send is dropped, and a receive in the same cycle is not accepted (`recv_ready` is forced 0 that cycle).

## Timing
- **Reset values:**
  - `send_valid=0`, `send_count=0`, `insert_valid=0`, `insert_hole=0`, `garbage_pending=0`.
  - `recv_ready=1` (queue empty).
  - State IDLE, `lines_sent_q=0`.
- **Latency:** delta visible in IDLE → CANCEL next edge. CANCEL takes 1 cycle per touched entry plus 1 exit cycle. `send_valid` rises the edge after CANCEL exit.
- **Full queue:** `recv_ready` comes from registered occupancy, so a pop in the same cycle does not permit a push while full.
- **Same-cycle receive and modify:** a push in the same cycle as a head decrement/pop updates both. When occupancy is 0, the new entry is not eligible for that cycle's CANCEL/INSERT step.
- **`lock_done` outside IDLE:** `lock_done` during CANCEL/SEND/INSERT still sets `insert_req`, which is serviced on a later IDLE.
- **Async reset mid-operation:** returns to reset values immediately. No partial entry survives.

## Configuration
- **`GARBAGE_CANCEL_EN` defined:** CANCEL behaves as above.
- **`GARBAGE_CANCEL_EN` undefined:** CANCEL is a single pass-through cycle. The queue is untouched, and the full `delta` goes to SEND whenever `delta>0`.

## Test plan
- Receive (3, hole 4) and (2, hole 7), then `lines_sent` 0→4 → queue becomes (1, hole 7); `garbage_pending=1`; no `send_valid`.
- Queue (2, hole 1), `lines_sent` 0→5 → `send_valid` with `send_count=3`; queue empty; held 3 cycles with `send_ready=0` and stable.
- Queue (10, hole 3), `lock_done && !lock_cleared`, `insert_ready=1` → exactly 8 rows with hole 3; `garbage_pending=2`. A lock with `lock_cleared=1` inserts 0 rows.
- Push 8 entries → `recv_ready=0`; a 9th `recv_valid` is ignored; one INSERT pop does not raise `recv_ready` until the following cycle.
- `game_start` during SEND with 5 pending rows → next cycle IDLE, `send_valid=0`, `garbage_pending=0`; `lines_sent` 0→2 then gives `send_count=2`.
- With `GARBAGE_CANCEL_EN` undefined: queue (3, hole 0), `lines_sent` 0→2 → `send_count=2`; `garbage_pending` stays 3.

Source files
------------

// File: rtl/garbage_queue.sv
// garbage_queue: turns lines_sent increases into outgoing attacks, queues incoming garbage, feeds rows after no-clear locks.
// Define GARBAGE_CANCEL_EN to let outgoing lines cancel queued incoming garbage before sending.
module garbage_queue #(
   parameter int DEPTH = 8,
   parameter int PLAYFIELD_COLS = 10,
   parameter int MAX_INSERT = 8
) (
   input  logic       clk,
   input  logic       rst_l,
   input  logic       game_start,
   input  logic [9:0] lines_sent,
   input  logic       lock_done,
   input  logic       lock_cleared,
   input  logic       recv_valid,
   input  logic [3:0] recv_count,
   input  logic [3:0] recv_hole,
   output logic       recv_ready,
   output logic       send_valid,
   output logic [9:0] send_count,
   input  logic       send_ready,
   output logic       insert_valid,
   output logic [3:0] insert_hole,
   input  logic       insert_ready,
   output logic [7:0] garbage_pending
);
   localparam int AW = $clog2(DEPTH);
   localparam int BW = $clog2(MAX_INSERT + 1);
   localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);
   localparam logic [4:0] COLS = 5'(PLAYFIELD_COLS);
   localparam logic [3:0] HOLE_MAX = 4'(PLAYFIELD_COLS - 1);
   typedef enum logic [1:0] {IDLE, CANCEL, SEND, INSERT} state_t;
   state_t state;
   logic [7:0] mem [DEPTH];
   logic [AW-1:0] head, tail;
   logic [AW:0] occ;
   logic [9:0] lines_sent_q, rem, delta;
   logic [BW-1:0] budget;
   logic insert_req;
   logic [7:0] pending, removed;
   logic [3:0] head_count, hole_in, new_count;
   logic empty, push, pop, dec, ins_hs, cancel_step, cancel_pop;
   assign empty = occ == '0;
   assign head_count = mem[head][7:4];
   assign recv_ready = occ != FULL_OCC && !game_start;
   assign push = recv_valid && recv_ready && recv_count != 4'd0;
   assign hole_in = {1'b0, recv_hole} >= COLS ? HOLE_MAX : recv_hole;
   assign delta = lines_sent - lines_sent_q;
   assign send_valid = state == SEND;
   assign send_count = send_valid ? rem : '0;
   assign insert_valid = state == INSERT && !empty && budget != '0;
   assign insert_hole = insert_valid ? mem[head][3:0] : 4'd0;
   assign garbage_pending = pending;
   assign ins_hs = insert_valid && insert_ready;
`ifdef GARBAGE_CANCEL_EN
   assign cancel_step = state == CANCEL && !empty && rem != '0;
`else
   assign cancel_step = 1'b0;
`endif
   assign cancel_pop = cancel_step && rem >= {6'd0, head_count};
   assign pop = cancel_pop || (ins_hs && head_count == 4'd1);
   assign dec = (cancel_step && !cancel_pop) || (ins_hs && head_count != 4'd1);
   // a partial cancel only happens with rem < head_count, so rem fits in 4 bits there
   assign new_count = cancel_step ? head_count - rem[3:0] : head_count - 4'd1;
   assign removed = cancel_pop ? {4'd0, head_count} : cancel_step ? {4'd0, rem[3:0]} : {7'd0, ins_hs};
   always_ff @(posedge clk) begin
      if (push) mem[tail] <= {recv_count, hole_in};
      if (dec) mem[head][7:4] <= new_count;
   end
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state <= IDLE;
         head <= '0;
         tail <= '0;
         occ <= '0;
         lines_sent_q <= '0;
         rem <= '0;
         budget <= '0;
         insert_req <= 1'b0;
         pending <= '0;
      end else if (game_start) begin
         state <= IDLE;
         head <= '0;
         tail <= '0;
         occ <= '0;
         lines_sent_q <= '0;
         rem <= '0;
         insert_req <= 1'b0;
         pending <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop) head <= head + 1'b1;
         occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
         pending <= pending + {4'd0, push ? recv_count : 4'd0} - removed;
         insert_req <= (lock_done && !lock_cleared) || (insert_req && !(state == IDLE && delta == '0));
         case (state)
            IDLE:
               if (delta != '0) begin
                  state <= CANCEL;
                  rem <= delta;
                  lines_sent_q <= lines_sent;
               end else if (insert_req) begin
                  state <= INSERT;
                  budget <= BW'(MAX_INSERT);
               end
            CANCEL:
               if (!cancel_step) state <= rem != '0 ? SEND : IDLE;
               else rem <= cancel_pop ? rem - {6'd0, head_count} : '0;
            SEND:
               if (send_ready) state <= IDLE;
            default:
               if (!insert_valid) state <= IDLE;
               else if (ins_hs) budget <= budget - 1'b1;
         endcase
      end
   end
endmodule

// File: tb/tb_garbage_queue.sv
// tb_garbage_queue: directed and random stimulus against a queue-based model of garbage_queue.
module tb_garbage_queue;
   localparam int DEPTH = 8, COLS = 10, MAXI = 8;
`ifdef GARBAGE_CANCEL_EN
   localparam bit CEN = 1'b1;
`else
   localparam bit CEN = 1'b0;
`endif
   logic clk = 0, rst_l = 0, game_start = 0, lock_done = 0, lock_cleared = 0;
   logic recv_valid = 0, send_ready = 0, insert_ready = 0;
   logic [9:0] lines_sent = 0;
   logic [3:0] recv_count = 0, recv_hole = 0;
   logic recv_ready, send_valid, insert_valid;
   logic [9:0] send_count;
   logic [3:0] insert_hole;
   logic [7:0] garbage_pending;
   int tests = 0, fails = 0;
   always #5 clk = ~clk;
   garbage_queue #(.DEPTH(DEPTH), .PLAYFIELD_COLS(COLS), .MAX_INSERT(MAXI)) dut (
      .clk(clk), .rst_l(rst_l), .game_start(game_start), .lines_sent(lines_sent),
      .lock_done(lock_done), .lock_cleared(lock_cleared), .recv_valid(recv_valid),
      .recv_count(recv_count), .recv_hole(recv_hole), .recv_ready(recv_ready),
      .send_valid(send_valid), .send_count(send_count), .send_ready(send_ready),
      .insert_valid(insert_valid), .insert_hole(insert_hole), .insert_ready(insert_ready),
      .garbage_pending(garbage_pending)
   );
   task automatic check(string name, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   // model: queue of (rows, hole) entries plus the phase of the outgoing/insert flow
   int qc[$], qh[$];
   int ph = 0, rem = 0, budget = 0, lsq = 0;
   bit ireq = 0;
   function automatic int qsum();
      int s = 0;
      foreach (qc[i]) s += qc[i];
      return s;
   endfunction
   task automatic model_flush();
      qc.delete();
      qh.delete();
      ph = 0;
      rem = 0;
      lsq = 0;
      ireq = 0;
   endtask
   task automatic model_step();
      bit push, enter;
      int d;
      push = recv_valid && qc.size() < DEPTH && recv_count != 0;
      d = (int'(lines_sent) - lsq) & 1023;
      enter = 0;
      if (ph == 0) begin
         if (d != 0) begin ph = 1; rem = d; lsq = int'(lines_sent); end
         else if (ireq) begin ph = 3; budget = MAXI; enter = 1; end
      end else if (ph == 1) begin
         if (!CEN || qc.size() == 0 || rem == 0) ph = rem > 0 ? 2 : 0;
         else if (rem >= qc[0]) begin rem -= qc[0]; void'(qc.pop_front()); void'(qh.pop_front()); end
         else begin qc[0] = qc[0] - rem; rem = 0; end
      end else if (ph == 2) begin
         if (send_ready) ph = 0;
      end else begin
         if (qc.size() == 0 || budget == 0) ph = 0;
         else if (insert_ready) begin
            qc[0] = qc[0] - 1;
            if (qc[0] == 0) begin void'(qc.pop_front()); void'(qh.pop_front()); end
            budget--;
         end
      end
      ireq = (lock_done && !lock_cleared) || (ireq && !enter);
      if (push) begin
         qc.push_back(int'(recv_count));
         qh.push_back(recv_hole >= COLS ? COLS - 1 : int'(recv_hole));
      end
   endtask
   initial forever begin
      @(posedge clk or negedge rst_l);
      if (!rst_l || game_start) model_flush();
      else model_step();
   end
   always @(negedge clk) begin
      bit ev;
      if (rst_l) begin
         ev = ph == 3 && qc.size() > 0 && budget > 0;
         check("recv_ready", recv_ready, qc.size() < DEPTH && !game_start);
         check("send_valid", send_valid, ph == 2);
         check("insert_valid", insert_valid, ev);
         check("garbage_pending", garbage_pending, qsum());
         if (ph == 2) check("send_count", send_count, rem);
         if (ev) check("insert_hole", insert_hole, qh[0]);
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic recv(int c, int h);
      recv_valid = 1;
      recv_count = 4'(c);
      recv_hole = 4'(h);
      tick();
      recv_valid = 0;
   endtask
   task automatic flush();
      game_start = 1;
      lines_sent = 0;
      send_ready = 0;
      insert_ready = 0;
      lock_done = 0;
      lock_cleared = 0;
      tick();
      game_start = 0;
   endtask
   task automatic wait_send(string name);
      int n = 0;
      while (!send_valid && n < 12) begin tick(); n++; end
      check(name, send_valid, 1);
   endtask
   initial begin
      int rows, bad, n, last;
      bit seen;
      repeat (3) tick();
      rst_l = 1;
      check("rst_send_valid", send_valid, 0);
      check("rst_send_count", send_count, 0);
      check("rst_insert_valid", insert_valid, 0);
      check("rst_insert_hole", insert_hole, 0);
      check("rst_pending", garbage_pending, 0);
      check("rst_recv_ready", recv_ready, 1);
      // two entries, then 4 outgoing lines
      recv(3, 4);
      recv(2, 7);
      lines_sent = 4;
      send_ready = 1;
      seen = 0;
      repeat (8) begin seen |= send_valid; tick(); end
      check("A_saw_send", seen, !CEN);
      check("A_pending", garbage_pending, CEN ? 1 : 5);
      flush();
      recv(2, 1);
      lines_sent = 5;
      wait_send("B_wait");
      check("B_count", send_count, CEN ? 3 : 5);
      check("B_pending", garbage_pending, CEN ? 0 : 2);
      repeat (3) begin
         tick();
         check("B_hold_valid", send_valid, 1);
         check("B_hold_count", send_count, CEN ? 3 : 5);
      end
      send_ready = 1;
      tick();
      check("B_done", send_valid, 0);
      flush();
      recv(10, 3);
      insert_ready = 1;
      lock_done = 1;
      tick();
      lock_done = 0;
      rows = 0;
      bad = 0;
      repeat (20) begin
         if (insert_valid) begin rows++; if (insert_hole != 3) bad++; end
         tick();
      end
      check("C_rows", rows, 8);
      check("C_bad_holes", bad, 0);
      check("C_pending", garbage_pending, 2);
      lock_done = 1;
      lock_cleared = 1;
      tick();
      lock_done = 0;
      lock_cleared = 0;
      rows = 0;
      repeat (10) begin if (insert_valid) rows++; tick(); end
      check("C_cleared_rows", rows, 0);
      check("C_cleared_pending", garbage_pending, 2);
      flush();
      for (int i = 0; i < 8; i++) recv(1, i);
      check("D_full_ready", recv_ready, 0);
      check("D_pending8", garbage_pending, 8);
      recv(4, 5);
      check("D_ninth_ignored", garbage_pending, 8);
      lock_done = 1;
      tick();
      lock_done = 0;
      n = 0;
      while (!insert_valid && n < 10) begin tick(); n++; end
      check("D_insert_valid", insert_valid, 1);
      check("D_ready_before_pop", recv_ready, 0);
      insert_ready = 1;
      recv_valid = 1;
      recv_count = 5;
      recv_hole = 2;
      tick();
      insert_ready = 0;
      recv_valid = 0;
      check("D_ready_after_pop", recv_ready, 1);
      check("D_pending_after_pop", garbage_pending, 7);
      flush();
      lines_sent = 3;
      wait_send("E_wait");
      recv(5, 2);
      check("E_pending5", garbage_pending, 5);
      check("E_still_send", send_valid, 1);
      game_start = 1;
      lines_sent = 0;
      recv_valid = 1;
      recv_count = 6;
      recv_hole = 1;
      #1;
      check("E_gs_ready", recv_ready, 0);
      tick();
      game_start = 0;
      recv_valid = 0;
      check("E_gs_send_valid", send_valid, 0);
      check("E_gs_pending", garbage_pending, 0);
      lines_sent = 2;
      wait_send("E_wait2");
      check("E_count2", send_count, 2);
      send_ready = 1;
      tick();
      flush();
      recv(3, 0);
      lines_sent = 2;
      send_ready = 1;
      seen = 0;
      last = 0;
      repeat (6) begin if (send_valid) begin seen = 1; last = send_count; end tick(); end
      check("G_saw_send", seen, !CEN);
      check("G_count", last, CEN ? 0 : 2);
      check("G_pending", garbage_pending, CEN ? 1 : 3);
      flush();
      recv(6, 1);
      lines_sent = 1;
      tick();
      @(posedge clk);
      #2;
      rst_l = 0;
      #1;
      check("R_pending", garbage_pending, 0);
      check("R_recv_ready", recv_ready, 1);
      check("R_send_valid", send_valid, 0);
      check("R_insert_valid", insert_valid, 0);
      lines_sent = 0;
      tick();
      rst_l = 1;
      for (int c = 0; c < 4000; c++) begin
         recv_valid = $urandom_range(0, 9) < 4;
         recv_count = 4'($urandom_range(0, 15));
         recv_hole = 4'($urandom_range(0, 15));
         lock_done = $urandom_range(0, 9) < 2;
         lock_cleared = 1'($urandom_range(0, 1));
         send_ready = 1'($urandom_range(0, 1));
         insert_ready = $urandom_range(0, 9) < 6;
         game_start = $urandom_range(0, 199) == 0;
         if ($urandom_range(0, 9) == 0) lines_sent = lines_sent + 10'($urandom_range(1, 4));
         if ($urandom_range(0, 299) == 0) lines_sent = lines_sent + 10'd1020;
         tick();
      end
      recv_valid = 0;
      lock_done = 0;
      game_start = 0;
      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
